// File: rtl/pcileech_tlp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_tlp_tx_arb
// Purpose  : Packet-granular round-robin arbiter that merges several 64-bit
//            AXI-stream TLP sources onto the single TX port of the PCIe core.
//            TLPs are never interleaved. Packets longer than PARAM_MAX_BEATS
//            are cut with a forced tlast and the rest of the packet is
//            drained. While the link is down, every source is flushed.
// Ports    : clk, rst (async, active-high)  - clock / reset
//            link_up                          - PCIe user link status
//            src_tdata/tkeep/tlast/tvalid     - per-source input streams
//            src_tready                       - per-source accept
//            m_tdata/tkeep/tlast/tvalid       - registered stream to the core
//            m_tready                         - core accept
//            grant                            - current owner index
//            busy                             - high in XFER or DRAIN
//            err_overlen                      - pulse on a truncated packet
//            pkt_cnt                          - TLPs delivered (mod 2^16)
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_tlp_tx_arb #(
   parameter int PARAM_NUM_SRC   = 3,
   parameter int PARAM_MAX_BEATS = 130
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         link_up,
   input  logic [64*PARAM_NUM_SRC-1:0]  src_tdata,
   input  logic [8*PARAM_NUM_SRC-1:0]   src_tkeep,
   input  logic [PARAM_NUM_SRC-1:0]     src_tlast,
   input  logic [PARAM_NUM_SRC-1:0]     src_tvalid,
   output logic [PARAM_NUM_SRC-1:0]     src_tready,
   output logic [63:0]                  m_tdata,
   output logic [7:0]                   m_tkeep,
   output logic                         m_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [2:0]                   grant,
   output logic                         busy,
   output logic                         err_overlen,
   output logic [15:0]                  pkt_cnt
);

   localparam logic [2:0] c_LAST_GRANT_RST = 3'(PARAM_NUM_SRC - 1);
   localparam logic [7:0] c_BEAT_LIMIT     = 8'(PARAM_MAX_BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XFER  = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [2:0]  r_grant;
   logic [2:0]  r_last_grant;
   logic [7:0]  r_beat_cnt;
   logic [63:0] r_tdata;
   logic [7:0]  r_tkeep;
   logic        r_tlast;
   logic        r_tvalid;
   logic        r_busy;
   logic        r_err_overlen;
   logic [15:0] r_pkt_cnt;

   logic        w_out_free;
   logic        w_sel_valid;
   logic        w_sel_last;
   logic [63:0] w_sel_data;
   logic [7:0]  w_sel_keep;
   logic        w_any_valid;
   logic        w_hi_found;
   logic [2:0]  w_hi_pick;
   logic [2:0]  w_lo_pick;
   logic [2:0]  w_rr_pick;
   logic        w_grant_load;
   logic        w_load;
   logic        w_overlen;
   logic        w_pkt_done;
   logic        w_abandon;

   // The output register can take a new beat when empty or emptying.
   assign w_out_free = !r_tvalid || m_tready;

   // Mux of the currently granted source.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      w_sel_keep  = '0;
      for (int i = 0; i < PARAM_NUM_SRC; i++) begin
         if (r_grant == 3'(i)) begin
            w_sel_valid = src_tvalid[i];
            w_sel_last  = src_tlast[i];
            w_sel_data  = src_tdata[64*i +: 64];
            w_sel_keep  = src_tkeep[8*i +: 8];
         end
      end
   end

   // Round-robin pick: lowest valid index above last_grant wins, otherwise
   // the search wraps to the lowest valid index at or below last_grant.
   always_comb begin
      w_any_valid = |src_tvalid;
      w_hi_found  = 1'b0;
      w_hi_pick   = '0;
      w_lo_pick   = '0;
      for (int i = PARAM_NUM_SRC - 1; i >= 0; i--) begin
         if (src_tvalid[i]) begin
            if (3'(i) > r_last_grant) begin
               w_hi_found = 1'b1;
               w_hi_pick  = 3'(i);
            end else begin
               w_lo_pick  = 3'(i);
            end
         end
      end
      w_rr_pick = w_hi_found ? w_hi_pick : w_lo_pick;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, source ready and datapath strobes.
   always_comb begin
      w_state_nxt  = r_state;
      src_tready   = '0;
      w_grant_load = 1'b0;
      w_load       = 1'b0;
      w_overlen    = 1'b0;
      w_pkt_done   = 1'b0;
      w_abandon    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!link_up) begin
               w_state_nxt = S_FLUSH;
            end else if (w_any_valid) begin
               w_grant_load = 1'b1;
               w_state_nxt  = S_XFER;
            end
         end
         S_XFER: begin
            for (int i = 0; i < PARAM_NUM_SRC; i++) begin
               src_tready[i] = (r_grant == 3'(i)) && w_out_free;
            end
            if (!link_up) begin
               // Core is resetting: drop the partial TLP, discard this beat
               // and sink the rest of the packet unless it just ended.
               w_abandon   = 1'b1;
               w_state_nxt = (w_sel_valid && w_out_free && w_sel_last) ? S_IDLE : S_DRAIN;
            end else if (w_sel_valid && w_out_free) begin
               w_load = 1'b1;
               if (w_sel_last) begin
                  w_pkt_done  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (r_beat_cnt == c_BEAT_LIMIT) begin
                  w_overlen   = 1'b1;
                  w_pkt_done  = 1'b1;
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            for (int i = 0; i < PARAM_NUM_SRC; i++) begin
               src_tready[i] = (r_grant == 3'(i));
            end
            if (w_sel_valid && w_sel_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FLUSH: begin
            src_tready = '1;
            if (link_up && !w_any_valid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant       <= '0;
         r_last_grant  <= c_LAST_GRANT_RST;
         r_beat_cnt    <= '0;
         r_tdata       <= '0;
         r_tkeep       <= '0;
         r_tlast       <= 1'b0;
         r_tvalid      <= 1'b0;
         r_busy        <= 1'b0;
         r_err_overlen <= 1'b0;
         r_pkt_cnt     <= '0;
      end else begin
         if (w_grant_load) begin
            r_grant    <= w_rr_pick;
            r_beat_cnt <= '0;
         end else if (w_load) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end

         if (w_pkt_done) begin
            r_last_grant <= r_grant;
            r_pkt_cnt    <= r_pkt_cnt + 16'd1;
         end

         r_err_overlen <= w_overlen;

         if ((r_state == S_FLUSH) || w_abandon) begin
            r_tvalid <= 1'b0;
         end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_sel_data;
            r_tkeep  <= w_sel_keep;
            r_tlast  <= w_sel_last || w_overlen;
         end else if (m_tready) begin
            r_tvalid <= 1'b0;
         end

         r_busy <= (w_state_nxt == S_XFER) || (w_state_nxt == S_DRAIN);
      end
   end

   assign m_tdata     = r_tdata;
   assign m_tkeep     = r_tkeep;
   assign m_tlast     = r_tlast;
   assign m_tvalid    = r_tvalid;
   assign grant       = r_grant;
   assign busy        = r_busy;
   assign err_overlen = r_err_overlen;
   assign pkt_cnt     = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcileech_tlp_tx_arb
// Purpose  : Self-checking bench for pcileech_tlp_tx_arb. Per-source packet
//            queues feed the DUT; a round-robin reference over those queues
//            predicts the output beat stream into a scoreboard that a
//            separate monitor pops on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_tlp_tx_arb;

   localparam int N    = 3;
   localparam int MAXB = 130;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        first;
   } beat_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [2:0]  src;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              link_up;
   logic [64*N-1:0]   src_tdata;
   logic [8*N-1:0]    src_tkeep;
   logic [N-1:0]      src_tlast;
   logic [N-1:0]      src_tvalid;
   logic [N-1:0]      src_tready;
   logic [63:0]       m_tdata;
   logic [7:0]        m_tkeep;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [2:0]        grant;
   logic              busy;
   logic              err_overlen;
   logic [15:0]       pkt_cnt;

   always #5 clk = ~clk;

   pcileech_tlp_tx_arb #(
      .PARAM_NUM_SRC   (N),
      .PARAM_MAX_BEATS (MAXB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .link_up     (link_up),
      .src_tdata   (src_tdata),
      .src_tkeep   (src_tkeep),
      .src_tlast   (src_tlast),
      .src_tvalid  (src_tvalid),
      .src_tready  (src_tready),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tlast     (m_tlast),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .grant       (grant),
      .busy        (busy),
      .err_overlen (err_overlen),
      .pkt_cnt     (pkt_cnt)
   );

   // Stimulus queues (driven into the DUT) and reference-model copies.
   beat_t srcq   [N][$];
   beat_t mbeats [N][$];
   int    plen   [N][$];
   exp_t  exp_q  [$];

   int checks     = 0;
   int failures   = 0;
   int model_last = N - 1;
   int exp_pkts   = 0;
   int exp_ovl    = 0;
   int seen_ovl   = 0;
   int gap        = -1;
   int tready_mode = 0;
   bit gaps_en    = 1'b0;
   bit abort      = 1'b0;
   bit strict     = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   // Queue one packet on source s; when to_model is set the reference model
   // also expects it on the output.
   function automatic void add_pkt(int s, int len, bit to_model);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data  = {$urandom, $urandom};
         b.keep  = 8'($urandom);
         b.last  = (i == len - 1);
         b.first = (i == 0);
         srcq[s].push_back(b);
         if (to_model) mbeats[s].push_back(b);
      end
      if (to_model) plen[s].push_back(len);
   endfunction

   // Reference: serve whole packets from non-empty source queues in
   // round-robin order, truncating anything longer than MAXB beats.
   function automatic void model_run();
      bit    found;
      int    s;
      int    len;
      beat_t b;
      exp_t  e;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         s     = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && plen[(model_last + k) % N].size() > 0) begin
               found = 1'b1;
               s     = (model_last + k) % N;
            end
         end
         if (found) begin
            len = plen[s].pop_front();
            for (int i = 0; i < len; i++) begin
               b = mbeats[s].pop_front();
               if (i < MAXB) begin
                  e.data = b.data;
                  e.keep = b.keep;
                  e.last = (i == len - 1) || (i == MAXB - 1);
                  e.src  = 3'(s);
                  exp_q.push_back(e);
               end
            end
            if (len > MAXB) exp_ovl++;
            exp_pkts++;
            model_last = s;
         end
      end
   endfunction

   function automatic bit src_pending();
      bit p = 1'b0;
      for (int s = 0; s < N; s++) if (srcq[s].size() > 0) p = 1'b1;
      return p;
   endfunction

   // Source and sink driver.
   initial begin
      bit hs [N];
      int cyc = 0;
      src_tvalid = '0;
      src_tdata  = '0;
      src_tkeep  = '0;
      src_tlast  = '0;
      m_tready   = 1'b1;
      forever begin
         @(negedge clk);
         for (int s = 0; s < N; s++) hs[s] = src_tvalid[s] && src_tready[s];
         @(posedge clk);
         #1;
         cyc++;
         case (tready_mode)
            1:       m_tready = ($urandom_range(0, 3) != 0);
            2:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_tready = 1'b1;
         endcase
         for (int s = 0; s < N; s++) begin
            if (abort) begin
               srcq[s].delete();
               src_tvalid[s] = 1'b0;
            end else begin
               if (hs[s]) begin
                  void'(srcq[s].pop_front());
                  src_tvalid[s] = 1'b0;
               end
               if (!src_tvalid[s] && srcq[s].size() > 0) begin
                  if (srcq[s][0].first || !gaps_en || $urandom_range(0, 2) != 0)
                     src_tvalid[s] = 1'b1;
               end
               if (srcq[s].size() > 0) begin
                  src_tdata[64*s +: 64] = srcq[s][0].data;
                  src_tkeep[8*s +: 8]   = srcq[s][0].keep;
                  src_tlast[s]          = srcq[s][0].last;
               end
            end
         end
      end
   end

   // Output monitor: scoreboard pops, stall stability, bubble, err_overlen.
   initial begin
      exp_t        e;
      bit          held = 1'b0;
      logic [63:0] hd;
      logic [7:0]  hk;
      logic        hl;
      forever begin
         @(negedge clk);
         if (rst || !link_up) begin
            held = 1'b0;
            if (rst) gap = -1;
         end else begin
            if (err_overlen) begin
               seen_ovl++;
               chk("overlen_with_tlast_beat", 64'({m_tvalid, m_tlast}), 64'd3);
            end
            if (held) begin
               chk("stall_valid", 64'(m_tvalid), 64'd1);
               chk("stall_data",  m_tdata, hd);
               chk("stall_keep",  64'(m_tkeep), 64'(hk));
               chk("stall_last",  64'(m_tlast), 64'(hl));
            end
            held = m_tvalid && !m_tready;
            hd = m_tdata;
            hk = m_tkeep;
            hl = m_tlast;
            if (m_tvalid && m_tready) begin
               if (gap >= 0) begin
                  if (strict) chk("bubble_between_pkts", 64'(gap), 64'd1);
                  gap = -1;
               end
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat: actual data=0x%0h required no beat", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", m_tdata, e.data);
                  chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
                  chk("beat_last", 64'(m_tlast), 64'(e.last));
                  if (!e.last) chk("beat_grant", 64'(grant), 64'(e.src));
               end
               if (m_tlast) gap = 0;
            end else if (!m_tvalid && gap >= 0) begin
               gap++;
            end
         end
      end
   end

   task automatic wait_idle(string tag);
      int n = 0;
      while ((exp_q.size() != 0 || src_pending() || m_tvalid || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_timeout: actual pending=%0d required 0", tag, exp_q.size());
      end
      repeat (3) @(negedge clk);
      chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(16'(exp_pkts)));
      chk({tag, "_overlen_cnt"}, 64'(seen_ovl), 64'(exp_ovl));
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      link_up = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid",    64'(m_tvalid), 64'd0);
      chk("rst_m_tlast",     64'(m_tlast), 64'd0);
      chk("rst_m_tdata",     m_tdata, 64'd0);
      chk("rst_m_tkeep",     64'(m_tkeep), 64'd0);
      chk("rst_src_tready",  64'(src_tready), 64'd0);
      chk("rst_busy",        64'(busy), 64'd0);
      chk("rst_err_overlen", 64'(err_overlen), 64'd0);
      chk("rst_pkt_cnt",     64'(pkt_cnt), 64'd0);
      chk("rst_grant",       64'(grant), 64'd0);
      rst = 1'b0;

      // Single source, arbitration latency.
      @(posedge clk);
      #1;
      add_pkt(1, 4, 1'b1);
      model_run();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!src_tvalid[1] && n < 10);
      @(negedge clk);
      chk("lat_c1_src_tready", 64'(src_tready), 64'd2);
      chk("lat_c1_grant",      64'(grant), 64'd1);
      chk("lat_c1_busy",       64'(busy), 64'd1);
      chk("lat_c1_m_tvalid",   64'(m_tvalid), 64'd0);
      @(negedge clk);
      chk("lat_c2_m_tvalid",   64'(m_tvalid), 64'd1);
      wait_idle("single");
      chk("single_grant", 64'(grant), 64'd1);

      // Fairness with continuous requests, one bubble between packets.
      @(posedge clk);
      #1;
      gap    = -1;
      strict = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < N; s++) add_pkt(s, 2, 1'b1);
      model_run();
      wait_idle("fair");
      strict = 1'b0;

      // Backpressure pattern 1,0,0,1.
      @(posedge clk);
      #1;
      tready_mode = 2;
      add_pkt(0, 6, 1'b1);
      model_run();
      wait_idle("bp");

      // Length boundaries: 140 (truncated), 130 (exact limit), 131.
      @(posedge clk);
      #1;
      tready_mode = 0;
      add_pkt(0, 140, 1'b1);
      add_pkt(0, 2, 1'b1);
      add_pkt(1, MAXB, 1'b1);
      add_pkt(2, MAXB + 1, 1'b1);
      add_pkt(2, 3, 1'b1);
      model_run();
      wait_idle("overlen");

      // Randomized traffic with source gaps and random backpressure.
      gaps_en     = 1'b1;
      tready_mode = 1;
      for (int r = 0; r < 4; r++) begin
         @(posedge clk);
         #1;
         for (int s = 0; s < N; s++) begin
            n = $urandom_range(0, 3);
            for (int p = 0; p < n; p++) add_pkt(s, $urandom_range(1, 8), 1'b1);
         end
         model_run();
         wait_idle("random");
      end

      // Link down for 20 cycles with sources valid.
      tready_mode = 0;
      @(posedge clk);
      #1;
      link_up = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < N; s++) begin
         add_pkt(s, 3, 1'b0);
         add_pkt(s, 3, 1'b0);
      end
      for (int c = 2; c < 20; c++) begin
         @(negedge clk);
         chk("flush_src_tready", 64'(src_tready), 64'd7);
         chk("flush_m_tvalid",   64'(m_tvalid), 64'd0);
      end
      @(posedge clk);
      #1;
      link_up = 1'b1;
      wait_idle("linkdown");
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) add_pkt(s, $urandom_range(2, 5), 1'b1);
      model_run();
      wait_idle("linkup");
      gaps_en = 1'b0;

      // Reset during beat 3 of a packet.
      @(posedge clk);
      #1;
      add_pkt(2, 10, 1'b1);
      model_run();
      n = 0;
      while (!m_tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      #2;
      rst   = 1'b1;
      abort = 1'b1;
      #1;
      chk("rstx_m_tvalid",    64'(m_tvalid), 64'd0);
      chk("rstx_m_tdata",     m_tdata, 64'd0);
      chk("rstx_m_tlast",     64'(m_tlast), 64'd0);
      chk("rstx_src_tready",  64'(src_tready), 64'd0);
      chk("rstx_busy",        64'(busy), 64'd0);
      chk("rstx_pkt_cnt",     64'(pkt_cnt), 64'd0);
      chk("rstx_grant",       64'(grant), 64'd0);
      exp_q.delete();
      for (int s = 0; s < N; s++) begin
         mbeats[s].delete();
         plen[s].delete();
      end
      model_last = N - 1;
      exp_pkts   = 0;
      exp_ovl    = 0;
      seen_ovl   = 0;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      add_pkt(1, 3, 1'b1);
      add_pkt(0, 3, 1'b1);
      model_run();
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rstx_next_grant", 64'(grant), 64'd0);
      wait_idle("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pcileech_tlp_tx_arb.md
# pcileech_tlp_tx_arb

Round-robin, packet-granular arbiter that shares the single 64-bit AXI-stream TLP transmit port of the Artix-7 PCIe core between several TLP sources, such as FIFO-forwarded host TLPs, config-space completions and internal BAR responses. It sits between those producers and the PCIe core's TX interface, in the PCIe clock domain. It guarantees that TLPs are never interleaved, caps runaway packets, and flushes sources while the link is down so the producers never stall.

## Interface
- PARAM_NUM_SRC, 3, number of requesting sources (2..8).
- PARAM_MAX_BEATS, 130, maximum 64-bit beats per TLP before forced termination.
- clk  in  1  core clock; all logic is in this domain.
- rst  in  1  asynchronous, active-high reset.
- link_up  in  1  PCIe user link up; level-sensitive.
- src_tdata  in  64*PARAM_NUM_SRC  per-source data; source i occupies [64*i+63:64*i].
- src_tkeep  in  8*PARAM_NUM_SRC  per-source byte enables.
- src_tlast  in  PARAM_NUM_SRC  per-source end of packet.
- src_tvalid  in  PARAM_NUM_SRC  per-source beat valid.
- src_tready  out  PARAM_NUM_SRC  per-source beat accept.
- m_tdata  out  64  data to the core.
- m_tkeep  out  8  byte enables to the core.
- m_tlast  out  1  end of packet to the core.
- m_tvalid  out  1  beat valid to the core.
- m_tready  in  1  core accept.
- grant  out  3  index of the source currently owning the port.
- busy  out  1  high while in XFER or DRAIN.
- err_overlen  out  1  one-cycle pulse when a packet is truncated at PARAM_MAX_BEATS.
- pkt_cnt  out  16  count of TLPs delivered to the core; wraps modulo 2^16.

## Operation
- State machine with four states: IDLE, XFER, DRAIN, FLUSH.
- **Output register.** m_* is one registered stage.
  - A beat is accepted from the selected source when src_tvalid[grant] & (!m_tvalid | m_tready).
  - Accepted data is loaded into m_*.
  - m_tvalid clears when m_tready is high and no new beat loads.
- **IDLE.** All src_tready=0.
  - If link_up=0, go to FLUSH.
  - Otherwise, if any src_tvalid is high, select the first valid source searching upward from (last_grant+1) mod PARAM_NUM_SRC, with wrap-around.
  - Register the selection into grant and go to XFER.
- **XFER.** src_tready[grant] = (!m_tvalid | m_tready). All other src_tready are 0.
  - The 8-bit beat counter increments per accepted beat and is cleared on entry.
  - Accepted beat with tlast: set last_grant=grant, increment pkt_cnt, go to IDLE.
  - Accepted beat that is beat number PARAM_MAX_BEATS without tlast: drive it out with m_tlast forced to 1 and pulse err_overlen.
    - Increment pkt_cnt and set last_grant=grant.
    - Go to DRAIN.
- **DRAIN.** src_tready[grant]=1 and beats are discarded (m_* unaffected). On an accepted tlast, go to IDLE.
- **FLUSH.** All src_tready=1 and all beats are discarded.
  - m_tvalid is forced to 0.
  - When link_up returns to 1 and no src_tvalid is high, go to IDLE.
- **link_up falls during XFER.**
  - m_tvalid clears on the next cycle; the partial TLP is abandoned because the core is resetting.
  - pkt_cnt is not incremented.
  - Go to DRAIN if the current packet's tlast has not been accepted, then IDLE, then FLUSH.
- **Simultaneous requests.** The round-robin pointer ensures that no source is granted twice while another source has remained valid.
- **Reset values.** State=IDLE, last_grant=PARAM_NUM_SRC-1 (source 0 wins first), grant=0. All of the following are 0: src_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, busy, err_overlen, pkt_cnt.
- **Reset mid-packet.** Everything clears asynchronously. Sources must tolerate a truncated handshake.

## Timing
- Arbitration latency:
  - Cycle 0: src_tvalid rises in IDLE.
  - Cycle 1: grant is registered and src_tready[grant] is high.
  - Cycle 2: the first beat appears on m_tvalid.
- Steady-state throughput is one beat per cycle while m_tready=1 and the source stays valid.
- Between packets there is exactly one bubble cycle (the IDLE cycle).
- m_tready backpressure propagates combinationally to src_tready[grant] in the same cycle. There is no combinational path from src_tvalid to m_*.
- err_overlen is asserted in the same cycle that the forced-tlast beat loads into m_*.
- pkt_cnt updates in the cycle after the tlast beat is accepted from the source.
- busy is registered and follows the state.

## Test plan
- **Single source.** Source 1 sends a 4-beat TLP, m_tready=1, link_up=1 → m_* carries the same 4 beats with tlast on beat 4. First m_tvalid is 2 cycles after src_tvalid. pkt_cnt=1, grant=1.
- **Round-robin fairness.** Sources 0, 1 and 2 are continuously valid with 2-beat packets → grant sequence is 0,1,2,0,1,2. Packets are never interleaved, and there is 1 idle cycle between packets.
- **Backpressure.** m_tready toggles 1,0,0,1 during a 6-beat packet → no beat is lost or duplicated, and m_* holds stable while m_tready=0.
- **Over-length packet.** A 140-beat packet with PARAM_MAX_BEATS=130 → 130 beats out, with m_tlast on beat 130. err_overlen pulses once, the remaining 10 beats are drained, and the next source is then served.
- **Link down.** link_up=0 for 20 cycles with sources valid → src_tready all 1, m_tvalid=0, pkt_cnt unchanged. After link_up=1 and the sources go idle, normal arbitration resumes.
- **Reset mid-XFER.** rst is pulsed during beat 3 → all outputs are 0 immediately, and the next grant goes to source 0.
